limiter_scheduler: RTL

Time-multiplexes one shared soft-limiter core across `CHANNELS` audio channels within each sample period. On every `sampleClk` strobe the block snapshots all channel samples and their mode bits, issues them one per clock to the core, collects the results at a fixed latency, and publishes the whole frame atomically. It sits between the per-channel sample bus and the single limiter instance, so only one limiter's worth of logic is needed.

---
 rtl/limiter_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/limiter_scheduler.sv
// Shares one soft-limiter core across CHANNELS audio channels per sample frame.
// Define LIMITER_SCHED_OVERRUN_CNT_EN to build the saturating dropped-strobe counter.
module limiter_scheduler #(
    parameter int SIGWIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int CORELAT  = 2
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         sampleClk,
    input  logic [CHANNELS-1:0]          modeIn,
    input  logic [CHANNELS*SIGWIDTH-1:0] samplesIn,
    input  logic                         overrunClr,
    output logic                         coreStrobe,
    output logic                         coreMode,
    output logic [SIGWIDTH-1:0]          coreIn,
    input  logic [SIGWIDTH-1:0]          coreOut,
    output logic [CHANNELS*SIGWIDTH-1:0] samplesOut,
    output logic                         outValid,
    output logic                         busy,
    output logic                         overrun,
    output logic [7:0]                   overrunCount
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IW-1:0] LAST_CH = IW'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_reg;
    logic [IW-1:0]       ch_reg;
    logic [IW-1:0]       ch_next;
    logic [SIGWIDTH-1:0] shadow_reg [CHANNELS];
    logic [CHANNELS-1:0] shadow_mode_reg;
    logic [SIGWIDTH-1:0] result_reg [CHANNELS];
    logic                pipe_valid_reg [CORELAT];
    logic [IW-1:0]       pipe_idx_reg [CORELAT];
    logic [CHANNELS*SIGWIDTH-1:0] frame_next;
    logic                tap_valid;
    logic [IW-1:0]       tap_idx;
    logic                last_retire;
    logic                drop;

    assign ch_next     = ch_reg + 1'b1;
    assign tap_valid   = pipe_valid_reg[CORELAT-1];
    assign tap_idx     = pipe_idx_reg[CORELAT-1];
    assign last_retire = (state_reg == DRAIN) && tap_valid && (tap_idx == LAST_CH);
    assign drop        = sampleClk && ((state_reg == ISSUE) || (state_reg == DRAIN));

    // The final channel's result arrives on the same edge that publishes the frame,
    // so it is forwarded straight from the core rather than read back from result_reg.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            frame_next[k*SIGWIDTH +: SIGWIDTH] = result_reg[k];
            if (tap_valid && (tap_idx == IW'(k)))
                frame_next[k*SIGWIDTH +: SIGWIDTH] = coreOut;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg       <= IDLE;
            ch_reg          <= '0;
            shadow_mode_reg <= '0;
            for (int k = 0; k < CHANNELS; k++) shadow_reg[k] <= '0;
            coreStrobe      <= 1'b0;
            coreMode        <= 1'b0;
            coreIn          <= '0;
            samplesOut      <= '0;
            outValid        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            outValid <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (sampleClk) begin
                        for (int k = 0; k < CHANNELS; k++)
                            shadow_reg[k] <= samplesIn[k*SIGWIDTH +: SIGWIDTH];
                        shadow_mode_reg <= modeIn;
                        // Channel 0 goes out on the very next cycle, straight from the inputs.
                        coreStrobe      <= 1'b1;
                        coreIn          <= samplesIn[SIGWIDTH-1:0];
                        coreMode        <= modeIn[0];
                        ch_reg          <= '0;
                        busy            <= 1'b1;
                        state_reg       <= ISSUE;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                ISSUE: begin
                    if (ch_reg == LAST_CH) begin
                        coreStrobe <= 1'b0;
                        state_reg  <= DRAIN;
                    end else begin
                        ch_reg   <= ch_next;
                        coreIn   <= shadow_reg[ch_next];
                        coreMode <= shadow_mode_reg[ch_next];
                    end
                end
                DRAIN: begin
                    if (last_retire) begin
                        samplesOut <= frame_next;
                        outValid   <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Return tracker: tap CORELAT-1 lines up with the core result for that issue.
    generate
        for (genvar gi = 0; gi < CORELAT; gi++) begin : g_pipe
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    pipe_valid_reg[gi] <= 1'b0;
                    pipe_idx_reg[gi]   <= '0;
                end else if (gi == 0) begin
                    pipe_valid_reg[gi] <= coreStrobe;
                    pipe_idx_reg[gi]   <= ch_reg;
                end else begin
                    pipe_valid_reg[gi] <= pipe_valid_reg[(gi > 0) ? gi-1 : 0];
                    pipe_idx_reg[gi]   <= pipe_idx_reg[(gi > 0) ? gi-1 : 0];
                end
            end
        end

        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_result
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN)
                    result_reg[gi] <= '0;
                else if (tap_valid && (tap_idx == IW'(gi)))
                    result_reg[gi] <= coreOut;
            end
        end
    endgenerate

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
        else if (overrunClr)
            overrun <= 1'b0;
    end

`ifdef LIMITER_SCHED_OVERRUN_CNT_EN
    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            count_reg <= 8'd0;
        else if (drop && (count_reg != 8'hFF))
            count_reg <= count_reg + 8'd1;
    end

    assign overrunCount = count_reg;
`else
    assign overrunCount = 8'd0;
`endif

endmodule
